frame_buffer_read_fetcher: RTL and testbench



---
 rtl/frame_buffer_read_fetcher.sv | 159 +++++++++++++++
 tb/tb_frame_buffer_read_fetcher.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_read_fetcher.sv
// Frame-buffer read DMA: credit-limited burst reads from the DDR2 local interface
// into a show-ahead FIFO that feeds the pixel scan-out consumer.
module frame_buffer_read_fetcher #(
  parameter logic [22:0] BASE_ADDR   = 23'h000000,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned BURST       = 2,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        local_init_done,
  input  logic        local_ready,
  input  logic [31:0] local_rdata,
  input  logic        local_rdata_valid,
  output logic [22:0] local_address,
  output logic        local_read_req,
  output logic        local_burstbegin,
  output logic [1:0]  local_size,
  output logic        local_write_req,
  input  logic        pix_pop,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [22:0]   REQS    = 23'(FRAME_WORDS / BURST);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_E = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state;
  logic [22:0]   req_left;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem [FIFO_DEPTH];

  logic          accept;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          start;
  logic          can_req;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] remain;
  logic [AW-1:0] rd_ptr_nxt;

  assign local_size      = 2'(BURST);
  assign local_write_req = 1'b0;

  always_comb begin
    accept     = local_read_req & local_ready;
    push       = local_rdata_valid & (state != IDLE);
    push_ok    = push & (fifo_count != DEPTH_C);
    pop        = pix_pop & pix_valid;
    start      = frame_start & local_init_done & (state == IDLE);
    out_nxt    = outstanding + (accept ? BURST_C : '0) - CW'(push);
    cnt_nxt    = fifo_count + CW'(push_ok) - CW'(pop);
    remain     = fifo_count - CW'(pop);
    rd_ptr_nxt = rd_ptr + AW'(pop);
    // Credit uses post-edge occupancy so a request raised now can never overflow.
    can_req    = ({1'b0, cnt_nxt} + {1'b0, out_nxt} + {1'b0, BURST_C}) <= DEPTH_E;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      local_address    <= BASE_ADDR;
      req_left         <= '0;
      outstanding      <= '0;
      local_read_req   <= 1'b0;
      local_burstbegin <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      outstanding <= out_nxt;
      if (start)
        underflow <= 1'b0;
      else if (pix_pop && !pix_valid)
        underflow <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state            <= FETCH;
            busy             <= 1'b1;
            local_address    <= BASE_ADDR;
            req_left         <= REQS;
            local_read_req   <= can_req;
            local_burstbegin <= can_req;
          end
        end
        FETCH: begin
          if (accept) begin
            local_address <= local_address + 23'(BURST);
            req_left      <= req_left - 23'd1;
            if (req_left == 23'd1) begin
              state            <= DRAIN;
              local_read_req   <= 1'b0;
              local_burstbegin <= 1'b0;
            end else begin
              local_read_req   <= can_req;
              local_burstbegin <= can_req;
            end
          end else if (local_read_req) begin
            local_burstbegin <= 1'b0;
          end else begin
            local_read_req   <= can_req;
            local_burstbegin <= can_req;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= local_rdata;
  end

  // Head register is refilled from words already in memory, giving one cycle push-to-valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= cnt_nxt;
      pix_valid  <= (remain != '0);
      if (remain != '0)
        pix_data <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: tb/tb_frame_buffer_read_fetcher.sv
// Bench for frame_buffer_read_fetcher: latency-6 memory model with a pixel scoreboard.
module tb_frame_buffer_read_fetcher;

  localparam logic [22:0] BASE = 23'h7FFFFC;
  localparam int unsigned FW   = 16;
  localparam int unsigned BU   = 2;
  localparam int unsigned FD   = 8;
  localparam int          LAT  = 6;
  localparam int          REQS = FW / BU;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        local_init_done;
  logic        local_ready;
  logic [31:0] local_rdata;
  logic        local_rdata_valid;
  logic [22:0] local_address;
  logic        local_read_req;
  logic        local_burstbegin;
  logic [1:0]  local_size;
  logic        local_write_req;
  logic        pix_pop;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        busy;
  logic        frame_done;
  logic        underflow;

  always #5 clk = ~clk;

  frame_buffer_read_fetcher #(
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FW),
    .BURST      (BU),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .frame_start      (frame_start),
    .local_init_done  (local_init_done),
    .local_ready      (local_ready),
    .local_rdata      (local_rdata),
    .local_rdata_valid(local_rdata_valid),
    .local_address    (local_address),
    .local_read_req   (local_read_req),
    .local_burstbegin (local_burstbegin),
    .local_size       (local_size),
    .local_write_req  (local_write_req),
    .pix_pop          (pix_pop),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .busy             (busy),
    .frame_done       (frame_done),
    .underflow        (underflow)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          out_model = 0;
  int          done_cnt = 0;
  int          stall_idx = -1;
  int          stall_left = 0;
  logic [22:0] exp_addr = BASE;
  logic [7:0]  frame_tag = 8'd0;
  bit          held = 1'b0;
  bit          live = 1'b0;
  bit          uf_model = 1'b0;
  bit          start_legit = 1'b0;

  function automatic logic [31:0] mem_word(input logic [7:0] tag, input logic [22:0] a);
    return {tag, 1'b0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit          acc, pop, first, rdv;
    logic [31:0] w;
    resp_t       r;
    acc   = local_read_req && local_ready;
    pop   = pix_pop && pix_valid;
    rdv   = local_rdata_valid && reset_n;
    first = local_read_req && !held;
    check("burstbegin", 32'(local_burstbegin), 32'(first));
    if (held) check("req_hold", 32'(local_read_req), 32'(1));
    if (local_read_req) check("address", 32'(local_address), 32'(exp_addr));
    check("underflow", 32'(underflow), 32'(uf_model));
    if (pop) begin
      check("sb_avail", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("pix_data", pix_data, w);
      end
    end
    if (frame_done) begin
      done_cnt++;
      check("busy_at_done", 32'(busy), 32'(0));
      check("reqs_at_done", 32'(acc_cnt), 32'(REQS));
      check("outst_at_done", 32'(out_model), 32'(0));
    end
    if (start_legit) uf_model = 1'b0;
    else if (pix_pop && !pix_valid) uf_model = 1'b1;
    held = local_read_req && !acc;

    @(posedge clk);
    #1;
    cyc++;
    if (rdv && live) out_model--;
    if (acc) begin
      for (int unsigned i = 0; i < BU; i++) begin
        w = mem_word(frame_tag, exp_addr + 23'(i));
        rq.push_back('{cyc + LAT + int'(i), w});
        sb.push_back(w);
      end
      exp_addr  += 23'(BU);
      acc_cnt++;
      out_model += BU;
    end
    frame_start = 1'b0;
    start_legit = 1'b0;
    local_ready = 1'b1;
    if (local_read_req && acc_cnt == stall_idx && stall_left > 0) begin
      local_ready = 1'b0;
      stall_left--;
    end
    if (reset_n && rq.size() != 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      local_rdata_valid = 1'b1;
      local_rdata       = r.data;
    end else begin
      local_rdata_valid = 1'b0;
      local_rdata       = $urandom;
    end
  endtask

  task automatic chk_reset_vals();
    check("rst_read_req", 32'(local_read_req), 32'(0));
    check("rst_burstbegin", 32'(local_burstbegin), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_pix_valid", 32'(pix_valid), 32'(0));
    check("rst_underflow", 32'(underflow), 32'(0));
    check("rst_address", 32'(local_address), 32'(BASE));
    check("rst_size", 32'(local_size), 32'(BU));
    check("rst_write_req", 32'(local_write_req), 32'(0));
    check("rst_pix_data", pix_data, 32'(0));
  endtask

  task automatic start_frame();
    frame_tag++;
    exp_addr    = BASE;
    acc_cnt     = 0;
    out_model   = 0;
    live        = 1'b1;
    frame_start = 1'b1;
    start_legit = 1'b1;
    step();
    check("busy_on", 32'(busy), 32'(1));
    check("first_req", 32'(local_read_req), 32'(1));
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check("frame_done_seen", 32'(done_cnt - d0), 32'(1));
    repeat (12) step();
    check("single_done", 32'(done_cnt - d0), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n           = 1'b0;
    frame_start       = 1'b0;
    local_init_done   = 1'b0;
    local_ready       = 1'b1;
    local_rdata       = '0;
    local_rdata_valid = 1'b0;
    pix_pop           = 1'b0;
    #1;
    repeat (3) step();
    chk_reset_vals();
    reset_n = 1'b1;
    step();

    // start while controller not initialised is dropped
    frame_start = 1'b1;
    repeat (4) step();
    check("gate_busy", 32'(busy), 32'(0));
    check("gate_req", 32'(local_read_req), 32'(0));

    // frame 1: continuous pops, ready stall on 2nd request, spurious start in FETCH
    local_init_done = 1'b1;
    pix_pop         = 1'b1;
    stall_idx       = 1;
    stall_left      = 5;
    start_frame();
    repeat (3) step();
    check("uf_set", 32'(underflow), 32'(1));
    check("uf_pix_valid", 32'(pix_valid), 32'(0));
    frame_start = 1'b1;
    step();
    wait_done(300);
    check("f1_sb_empty", 32'(sb.size()), 32'(0));

    // frame 2: credit throttle with consumer stopped
    pix_pop   = 1'b0;
    stall_idx = -1;
    start_frame();
    check("uf_cleared", 32'(underflow), 32'(0));
    repeat (40) step();
    check("credit_reqs", 32'(acc_cnt), 32'(4));
    check("credit_req_low", 32'(local_read_req), 32'(0));
    check("credit_full_valid", 32'(pix_valid), 32'(1));
    pix_pop = 1'b1;
    step();
    step();
    pix_pop = 1'b0;
    repeat (30) step();
    check("credit_one_more", 32'(acc_cnt), 32'(5));
    check("credit_req_low2", 32'(local_read_req), 32'(0));
    pix_pop = 1'b1;
    wait_done(400);
    check("f2_sb_empty", 32'(sb.size()), 32'(0));

    // frame 3: reset with 4 words outstanding, then stray read data
    pix_pop = 1'b0;
    start_frame();
    n = 0;
    while (acc_cnt < 2 && n < 20) begin
      step();
      n++;
    end
    check("pre_reset_reqs", 32'(acc_cnt), 32'(2));
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    held      = 1'b0;
    live      = 1'b0;
    sb.delete();
    out_model = 0;
    uf_model  = 1'b0;
    exp_addr  = BASE;
    acc_cnt   = 0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (20) step();
    chk_reset_vals();

    // frame 4: clean fetch from BASE after reset
    pix_pop = 1'b1;
    start_frame();
    wait_done(300);
    check("f4_sb_empty", 32'(sb.size()), 32'(0));
    check("frames_done", 32'(done_cnt), 32'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
